// File: rtl/joy_input_capture_if.sv
// joy_input_capture_if
//   Byte-wide register bus between the system CPU and joy_input_capture.
//
//   Bus protocol: cpu_rd and cpu_wr are one-cycle strobes qualified by
//   cpu_addr (and cpu_din for writes). There is no ready/wait signal; the
//   slave accepts every strobe on the clk_sys edge where it is high. Read
//   data appears on cpu_dout one cycle after the cpu_rd edge and holds until
//   the next read. irq is a registered level.
//
//   Signals:
//     cpu_addr  [4:0]  register address        (master -> slave)
//     cpu_rd           read strobe             (master -> slave)
//     cpu_wr           write strobe            (master -> slave)
//     cpu_din   [7:0]  write data              (master -> slave)
//     cpu_dout  [7:0]  registered read data    (slave -> master)
//     irq              level interrupt         (slave -> master)
interface joy_input_capture_if;
  logic [4:0] cpu_addr;
  logic       cpu_rd;
  logic       cpu_wr;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       irq;

  modport master (
    output cpu_addr, cpu_rd, cpu_wr, cpu_din,
    input  cpu_dout, irq
  );

  modport slave (
    input  cpu_addr, cpu_rd, cpu_wr, cpu_din,
    output cpu_dout, irq
  );
endinterface

// File: rtl/joy_input_capture.sv
// joy_input_capture
//   Debounces the raw hps_io joystick words on a sample strobe, latches
//   sticky "pressed" events and exposes both through a byte-wide register
//   port with an optional level interrupt. Single clk_sys domain.
//
//   Ports:
//     clk_sys    system clock
//     reset      synchronous, active-high reset
//     sample_ce  one-cycle debounce sample strobe
//     joystick   PLAYERS*32 raw words; player p at [32p+31:32p], low 16 used
//     bus        register bus (cpu_addr/rd/wr/din/dout, irq), slave side
//
//   Register map (p = 0..PLAYERS-1):
//     4p+0 stable[7:0]  RO    4p+1 stable[15:8] RO
//     4p+2 event[7:0]   W1C   4p+3 event[15:8]  W1C
//     24   status: bit0 = any event pending
//     25   control: bit0 = irq_en
//     everything else reads 0x00, writes ignored
module joy_input_capture #(
  parameter int PLAYERS  = 6,
  parameter int BITS     = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   sample_ce,
  input  logic [PLAYERS*32-1:0]  joystick,
  joy_input_capture_if.slave     bus
);

  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE - 1);

  logic [BITS-1:0] raw      [PLAYERS];
  logic [BITS-1:0] stable_q [PLAYERS];
  logic [BITS-1:0] stable_d [PLAYERS];
  logic [BITS-1:0] evt_q    [PLAYERS];
  logic [BITS-1:0] evt_d    [PLAYERS];
  logic [BITS-1:0] clr_mask [PLAYERS];
  logic [BITS-1:0] rise     [PLAYERS];
  logic [3:0]      cnt_q    [PLAYERS][BITS];
  logic [3:0]      cnt_d    [PLAYERS][BITS];
  logic            irq_en_q;
  logic            irq_en_d;
  logic            any_evt_q;
  logic            any_evt_d;
  logic [7:0]      rd_data;
  logic [PLAYERS*(32-BITS)-1:0] unused_joy_hi;

  // The upper half of each hps_io word carries nothing we map.
  for (genvar gp = 0; gp < PLAYERS; gp++) begin : g_raw
    assign raw[gp] = joystick[32*gp +: BITS];
    assign unused_joy_hi[(32-BITS)*gp +: (32-BITS)] = joystick[32*gp+BITS +: (32-BITS)];
  end

  // Debounce, event latch and W1C in one place so that a set arriving on
  // the same cycle as a clear wins (set is OR-ed in after the clear).
  always_comb begin
    any_evt_d = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      stable_d[p] = stable_q[p];
      clr_mask[p] = '0;
      rise[p]     = '0;
      for (int b = 0; b < BITS; b++) cnt_d[p][b] = cnt_q[p][b];

      if (bus.cpu_wr && bus.cpu_addr == 5'(4*p + 2)) clr_mask[p][7:0]  = bus.cpu_din;
      if (bus.cpu_wr && bus.cpu_addr == 5'(4*p + 3)) clr_mask[p][15:8] = bus.cpu_din;

      if (sample_ce) begin
        for (int b = 0; b < BITS; b++) begin
          if (raw[p][b] == stable_q[p][b]) begin
            cnt_d[p][b] = 4'd0;
          end else if (cnt_q[p][b] == CNT_LAST) begin
            stable_d[p][b] = raw[p][b];
            cnt_d[p][b]    = 4'd0;
            rise[p][b]     = raw[p][b];   // only a 0->1 change raises an event
          end else begin
            cnt_d[p][b] = cnt_q[p][b] + 4'd1;
          end
        end
      end

      evt_d[p]  = (evt_q[p] & ~clr_mask[p]) | rise[p];
      any_evt_d = any_evt_d | (|evt_d[p]);
    end

    irq_en_d = irq_en_q;
    if (bus.cpu_wr && bus.cpu_addr == 5'd25) irq_en_d = bus.cpu_din[0];
  end

  // Read mux works on current state, so a combined rd+wr returns pre-write data.
  always_comb begin
    any_evt_q = 1'b0;
    rd_data   = 8'h00;
    for (int p = 0; p < PLAYERS; p++) begin
      any_evt_q = any_evt_q | (|evt_q[p]);
      if (bus.cpu_addr == 5'(4*p + 0)) rd_data = stable_q[p][7:0];
      if (bus.cpu_addr == 5'(4*p + 1)) rd_data = stable_q[p][15:8];
      if (bus.cpu_addr == 5'(4*p + 2)) rd_data = evt_q[p][7:0];
      if (bus.cpu_addr == 5'(4*p + 3)) rd_data = evt_q[p][15:8];
    end
    if (bus.cpu_addr == 5'd24) rd_data = {7'd0, any_evt_q};
    if (bus.cpu_addr == 5'd25) rd_data = {7'd0, irq_en_q};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int p = 0; p < PLAYERS; p++) begin
        stable_q[p] <= '0;
        evt_q[p]    <= '0;
        for (int b = 0; b < BITS; b++) cnt_q[p][b] <= 4'd0;
      end
      irq_en_q     <= 1'b0;
      bus.cpu_dout <= 8'h00;
      bus.irq      <= 1'b0;
    end else begin
      for (int p = 0; p < PLAYERS; p++) begin
        stable_q[p] <= stable_d[p];
        evt_q[p]    <= evt_d[p];
        for (int b = 0; b < BITS; b++) cnt_q[p][b] <= cnt_d[p][b];
      end
      irq_en_q <= irq_en_d;
      if (bus.cpu_rd) bus.cpu_dout <= rd_data;
      bus.irq <= irq_en_q & any_evt_d;
    end
  end

endmodule

// File: doc/joy_input_capture.md
Name: joy_input_capture

Overview:
- Conditions the raw per-player joystick words from hps_io before the system CPU sees them.
- Debounces each button bit on a sample strobe and latches sticky "pressed" events.
- Exposes stable state and event bits through a small byte-wide register port, with an optional level interrupt.
- Sits between hps_io joystick_0..5 and the system block's input bus, entirely in the clk_sys domain.

Parameters:
- PLAYERS, 6, number of joystick words captured; legal range 1..6.
- BITS, 16, low-order bits captured per player; fixed at 16 for the register map.
- DEBOUNCE, 4, consecutive differing samples required before the stable state changes; legal range 1..15.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sample_ce  in  1  one-cycle debounce sample strobe, e.g. once per line or frame.
- joystick  in  PLAYERS*32  concatenated raw words; player p occupies [32p+31:32p]; only [32p+15:32p] is used.
- cpu_addr  in  5  register address.
- cpu_rd  in  1  read strobe.
- cpu_wr  in  1  write strobe.
- cpu_din  in  8  write data.
- cpu_dout  out  8  registered read data.
- irq  out  1  level interrupt: asserted while enabled and any event is pending.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; clock port is clk_sys, reset port is reset.
- Reset clears every stable bit, event bit, debounce counter, irq_en, cpu_dout and irq.
- Raw inputs are used directly, with no synchroniser; hps_io already drives them on clk_sys.
- Per-bit debounce, evaluated only on cycles where sample_ce=1:
  - raw==stable: cnt<=0.
  - raw!=stable and cnt==DEBOUNCE-1: stable<=raw, cnt<=0.
  - otherwise: cnt<=cnt+1.
  - Each counter is 4 bits.
  - Without sample_ce, nothing changes.
- Event latch: a 0->1 transition of a stable bit sets the matching event bit in the same cycle the stable bit updates. A 1->0 transition sets nothing.
- Register map (p = 0..PLAYERS-1):
  - 4p+0: stable[7:0], read-only.
  - 4p+1: stable[15:8], read-only.
  - 4p+2: event[7:0], write-1-to-clear.
  - 4p+3: event[15:8], write-1-to-clear.
  - 24: status; bit0 = any event pending, bits[7:1]=0; read-only.
  - 25: control; bit0 = irq_en, read/write; other bits read 0.
  - All other addresses, including player slots >= PLAYERS, read 0x00; writes to them are ignored.
- Reads: cpu_dout updates on the clk_sys edge where cpu_rd=1, giving 1-cycle latency. It holds its value when cpu_rd=0, and reads have no side effects.
- Writes: take effect on the clk_sys edge where cpu_wr=1. cpu_rd and cpu_wr asserted together: both are performed, and the read returns the pre-write value.
- A W1C clear and an event set on the same bit in the same cycle: the set wins, and the bit reads 1 afterwards.
- irq is registered: irq <= irq_en & |event_next. It is valid one cycle after the causing edge.
- Reset mid-debounce discards partial counts. A button still held after reset needs DEBOUNCE samples to appear, then raises an event.

Test Plan:
- Reset, then read all addresses 0..31 -> all 0x00, irq=0.
- Player 0 raw bit4=1 held, DEBOUNCE=4, sample_ce every 8 clocks:
  - 3 strobes -> addr0 reads 0x00.
  - 4th strobe -> addr0=0x10, addr2=0x10, addr24=0x01.
- Glitch: raw bit0 of player 2 high for 3 strobes then low for 1, repeated 5 times -> addr8 stays 0x00 and addr10 stays 0x00.
- Event handling on player 1, irq enabled via write 0x01 to addr25:
  - Press bit9 -> irq=1 one cycle after the event edge, and addr7=0x02.
  - Write 0x02 to addr7 -> addr7=0x00 and irq drops the next cycle.
  - Release of bit9 raises no event.
- Simultaneous: W1C to addr2 of bit0 on the same cycle player 0 bit0 becomes stable-high -> addr2 bit0 reads 1.
- PLAYERS=2: read addr 8..23 -> 0x00; write 0xFF to addr10, then read -> 0x00.
- Assert reset while player 3 has a counter at 2 and event bits pending:
  - All registers read 0 after reset.
  - The held button re-appears after exactly 4 strobes.
